// File: rtl/ramb4_arb_pkg.sv
// Shared sizes and state encoding for the two-requester RAMB4_S8 port A controller.
package ramb4_arb_pkg;

   localparam int ADDR_W = 9;
   localparam int DATA_W = 8;
   localparam int DEPTH  = 512;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   typedef enum logic {
      CLEAR,
      RUN
   } state_t;

endpackage

// File: rtl/ramb4_arb_rr.sv
// Two-way round-robin picker: one-hot select among eligible requesters, pointer flips
// to the other requester whenever a grant is actually taken (i_adv).
module ramb4_arb_rr (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic [1:0] i_elig,
   input  logic       i_adv,
   output logic [1:0] o_sel
);

   logic r_pri;

   always_comb begin
      o_sel = i_elig;
      if (&i_elig) begin
         o_sel = r_pri ? 2'b10 : 2'b01;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_pri <= 1'b0;
      end else if (i_adv) begin
         r_pri <= o_sel[0];
      end
   end

endmodule

// File: rtl/ramb4_s8_arb2.sv
// Round-robin access controller for RAMB4_S8_S8 port A with optional zero-fill after reset.
// Define RAMB4_ARB_COLLISION_EN to withhold port A accesses that collide with port B.
module ramb4_s8_arb2
   import ramb4_arb_pkg::*;
#(
   parameter bit CLEAR_ON_RESET = 1'b0
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              REQ0,
   input  logic              REQ1,
   input  logic              WE0,
   input  logic              WE1,
   input  logic [ADDR_W-1:0] ADDR0,
   input  logic [ADDR_W-1:0] ADDR1,
   input  logic [DATA_W-1:0] DI0,
   input  logic [DATA_W-1:0] DI1,
   output logic              GNT0,
   output logic              GNT1,
   output logic              RVLD0,
   output logic              RVLD1,
   output logic [DATA_W-1:0] DO,
   output logic              BUSY,
   output logic              ENA,
   output logic              WEA,
   output logic [ADDR_W-1:0] ADDRA,
   output logic [DATA_W-1:0] DIA,
   output logic              RSTA,
   input  logic [DATA_W-1:0] DOA,
   input  logic              ENB_NXT,
   input  logic              WEB_NXT,
   input  logic [ADDR_W-1:0] ADDRB_NXT
);

   state_t            r_state;
   logic [ADDR_W-1:0] r_cnt;
   logic              r_ena;
   logic              r_wea;
   logic [ADDR_W-1:0] r_addra;
   logic [DATA_W-1:0] r_dia;
   logic [1:0]        r_gnt;
   logic [1:0]        r_rvld;
   logic              r_busy;

   logic [1:0]        w_elig;
   logic [1:0]        w_sel;
   logic              w_cand_valid;
   logic              w_cand_we;
   logic [ADDR_W-1:0] w_cand_addr;
   logic [DATA_W-1:0] w_cand_di;
   logic              w_stall;
   logic              w_go;
   logic              w_grant;

   // A request that is being acknowledged this cycle must not be taken a second time.
   assign w_elig = {REQ1 & ~r_gnt[1], REQ0 & ~r_gnt[0]} & {2{r_state == RUN}};

   ramb4_arb_rr u_rr (
      .CLK    (CLK),
      .RST_N  (RST_N),
      .i_elig (w_elig),
      .i_adv  (w_grant),
      .o_sel  (w_sel)
   );

   always_comb begin
      w_cand_we   = 1'b1;
      w_cand_addr = r_cnt;
      w_cand_di   = '0;
      if (r_state == RUN) begin
         if (w_sel[1]) begin
            w_cand_we   = WE1;
            w_cand_addr = ADDR1;
            w_cand_di   = DI1;
         end else begin
            w_cand_we   = WE0;
            w_cand_addr = ADDR0;
            w_cand_di   = DI0;
         end
      end
   end

   assign w_cand_valid = (r_state == CLEAR) | (|w_sel);

`ifdef RAMB4_ARB_COLLISION_EN
   assign w_stall = w_cand_valid & ENB_NXT & (ADDRB_NXT == w_cand_addr) & (w_cand_we | WEB_NXT);
`else
   logic w_unused_portb;
   assign w_unused_portb = ^{ENB_NXT, WEB_NXT, ADDRB_NXT};
   assign w_stall        = 1'b0;
`endif

   assign w_go    = w_cand_valid & ~w_stall;
   assign w_grant = w_go & (r_state == RUN);

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state <= CLEAR_ON_RESET ? CLEAR : RUN;
         r_cnt   <= '0;
         r_ena   <= 1'b0;
         r_wea   <= 1'b0;
         r_addra <= '0;
         r_dia   <= '0;
         r_gnt   <= 2'b00;
         r_rvld  <= 2'b00;
         r_busy  <= CLEAR_ON_RESET;
      end else begin
         r_busy <= (r_state == CLEAR);
         r_rvld <= r_gnt & {2{~r_wea}};
         r_gnt  <= w_grant ? w_sel : 2'b00;
         r_ena  <= w_go;
         r_wea  <= w_go & w_cand_we;
         if (w_go) begin
            r_addra <= w_cand_addr;
            r_dia   <= w_cand_di;
         end
         // The fill stops on the last address rather than wrapping.
         if ((r_state == CLEAR) && w_go) begin
            if (r_cnt == LAST_ADDR) begin
               r_state <= RUN;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         end
      end
   end

   assign GNT0  = r_gnt[0];
   assign GNT1  = r_gnt[1];
   assign RVLD0 = r_rvld[0];
   assign RVLD1 = r_rvld[1];
   assign DO    = DOA;
   assign BUSY  = r_busy;
   assign ENA   = r_ena;
   assign WEA   = r_wea;
   assign ADDRA = r_addra;
   assign DIA   = r_dia;
   assign RSTA  = 1'b0;

endmodule

// File: doc/ramb4_s8_arb2.md
# ramb4_s8_arb2

Two-requester access controller for port A of the 512x8 dual-port block RAM (RAMB4_S8_S8 primitive). It round-robin arbitrates two command streams onto a single registered RAM port and tags returning read data with per-requester valid strobes. It can optionally zero-fill the whole array after reset. It sits directly between the RAM's port A pins and two client blocks; port B stays owned by a separate client.

## Interface
- CLEAR_ON_RESET, 0: when 1, write 8'h00 to all 512 locations after reset before granting anything.
- CLK  in  1  clock; also drives RAM CLKA.
- RST_N  in  1  asynchronous active-low reset.
- REQ0 / REQ1  in  1  request; held with its command until the matching GNT.
- WE0 / WE1  in  1  1 = write, 0 = read.
- ADDR0 / ADDR1  in  9  word address.
- DI0 / DI1  in  8  write data.
- GNT0 / GNT1  out  1  one-cycle acceptance pulse.
- RVLD0 / RVLD1  out  1  one-cycle pulse: DO holds that requester's read data.
- DO  out  8  read data, combinational pass-through of DOA.
- BUSY  out  1  high while the zero-fill runs.
- ENA, WEA  out  1  RAM port A enable and write enable.
- ADDRA  out  9  RAM port A address.
- DIA  out  8  RAM port A write data.
- RSTA  out  1  tied 0.
- DOA  in  8  RAM port A data out.
- ENB_NXT, WEB_NXT  in  1  port B enable and write enable for the next CLK edge. Used only with the collision feature.
- ADDRB_NXT  in  9  port B address for the next CLK edge. Used only with the collision feature.

## Operation
- States:
  - CLEAR: entered from reset only when CLEAR_ON_RESET=1.
  - RUN: entered from reset otherwise, and after the final CLEAR write.
- CLEAR behaviour:
  - 9-bit counter CNT counts 0..511; each cycle drives ENA=WEA=1, ADDRA=CNT, DIA=0.
  - After CNT=511 is issued, the next cycle goes to RUN. CNT does not wrap back to 0.
  - BUSY=1 throughout CLEAR; REQx are ignored and GNTx stay 0.
- Eligibility in RUN: requester x is eligible when REQx=1 and GNTx is currently 0. The same request is therefore never granted twice.
- Arbitration:
  - One eligible requester: it is granted.
  - Both eligible: pointer PRI picks the winner.
  - After any grant, PRI points to the other requester.
  - PRI resets to requester 0.
- Grant action, at the clock edge: GNTx<=1, ENA<=1, WEA<=WEx, ADDRA<=ADDRx, DIA<=DIx.
- No grant: ENA<=0 and WEA<=0. ADDRA and DIA keep their previous values.
- A granted read sets RVLDx=1 one cycle after GNTx. No RVLD is produced for writes.
- With both requesters continuously requesting, port A runs at one access per cycle, alternating 0,1,0,1.
- Reset mid-operation: all outputs go to their reset values immediately; in-flight RVLD is lost; CLEAR restarts from 0.

## Timing
- Reset values:
  - ENA, WEA, ADDRA, DIA, GNTx, RVLDx, RSTA = 0.
  - BUSY = CLEAR_ON_RESET.
- Edge t: request sampled; GNTx and port A outputs registered.
- Edge t+1: RAM executes the access. The requester sees GNTx here and may change its command.
- Cycle after t+1: RVLDx=1 and DO is valid (read latency = 2 edges from sample).
- Zero-fill takes exactly 512 cycles; first possible GNT is at edge 513 after reset release.

## Configuration
- RAMB4_ARB_COLLISION_EN defined:
  - A collision exists when the candidate access (grant or CLEAR write) has ADDR == ADDRB_NXT, ENB_NXT=1, and (WEx | WEB_NXT)=1.
  - On a collision the access is withheld for that cycle: no GNT, ENA=0. During CLEAR the counter holds.
  - PRI is unchanged by a withheld access; the access is retried on the next cycle.
  - Read/read on the same address is not a collision.
- Macro undefined: the ENB_NXT, WEB_NXT and ADDRB_NXT inputs are ignored; no stall logic.

## Structure
- Package ramb4_arb_pkg:
  - ADDR_W=9, DATA_W=8, DEPTH=512.
  - State enum {CLEAR, RUN}.
- Sub-module ramb4_arb_rr: 2-way round-robin picker holding PRI. Inputs are the eligible bits and an advance strobe; outputs are one-hot grant selects.

## Test plan
- CLEAR_ON_RESET=1, release reset: 512 cycles of ENA=WEA=1, ADDRA 0..511, DIA=0, BUSY=1; BUSY=0 at cycle 513; a read of 0x1FF then returns DO=0x00 with RVLD.
- REQ0 write 0x0A5 data 0x3C, then REQ0 read 0x0A5: GNT0 pulses for each; RVLD0 asserts one cycle after the read grant, with DO=0x3C.
- REQ0 and REQ1 both held for 8 reads starting from reset: grants alternate 0,1,0,1; ENA stays high every cycle; RVLD0 and RVLD1 alternate, each lagging its grant by one cycle.
- Only REQ1 held continuously: GNT1 pulses every other cycle; never two consecutive GNT1 cycles.
- RST_N dropped while RVLD0 is pending: all outputs are 0 immediately, with no RVLD0 after reset release.
- With RAMB4_ARB_COLLISION_EN defined:
  - REQ0 write 0x010 while ENB_NXT=1, ADDRB_NXT=0x010: no grant that cycle.
  - Change ADDRB_NXT to 0x011: GNT0 on the next cycle.
  - Read/read on the same address is granted immediately.
